// File: rtl/nn_axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : nn_axi_pkg                                            |
// | Purpose  : Shared AXI response codes, loader FSM state encoding  |
// |            and weight word geometry for the perceptron AXI glue. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package nn_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Bytes per weight word; consecutive weights are this far apart
  localparam int WEIGHT_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RESP  = 3'd3,
    ST_FIN   = 3'd4
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/axil_weight_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axil_weight_loader_if                                 |
// | Purpose  : AXI4-Lite write-only bus (AW, W, B channels) between  |
// |            the weight loader and the perceptron slave port.      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface axil_weight_loader_if #(
  parameter int ADDR_W = 12
) ();

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface
`default_nettype wire

// File: rtl/axil_weight_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : axil_weight_loader                                    |
// | Purpose  : Streams N_WEIGHTS 32-bit words from an AXI-Stream     |
// |            source into consecutive AXI4-Lite word addresses,     |
// |            one outstanding write at a time, with status outputs. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module axil_weight_loader
  import nn_axi_pkg::*;
#(
  parameter int N_WEIGHTS = 784,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 10
) (
  input  wire logic             s_axi_aclk,
  input  wire logic             s_axi_aresetn,
  input  wire logic             start,
  input  wire logic [31:0]      w_tdata,
  input  wire logic             w_tvalid,
  output logic                  w_tready,
  axil_weight_loader_if.master  M_AXI,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_W-1:0]      count
);

  localparam logic [ADDR_W-1:0] C_BASE_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  C_N_WEIGHTS = CNT_W'(N_WEIGHTS);

  // The whole vector must fit in the address space and the counter must reach N_WEIGHTS
  if ((longint'(BASE_ADDR) + longint'(WEIGHT_BYTES) * longint'(N_WEIGHTS))
      > (longint'(1) << ADDR_W)) begin : g_addr_range_check
    $fatal(1, "axil_weight_loader: weight vector exceeds the address space");
  end
  if ((longint'(1) << CNT_W) <= longint'(N_WEIGHTS)) begin : g_cnt_width_check
    $fatal(1, "axil_weight_loader: CNT_W too narrow for N_WEIGHTS");
  end

  loader_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
  logic [31:0]       r_wdata, w_wdata_nxt;
  logic              r_awvalid, w_awvalid_nxt;
  logic              r_wvalid, w_wvalid_nxt;
  logic              r_aw_done, w_aw_done_nxt;
  logic              r_w_done, w_w_done_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic [CNT_W-1:0]  w_count_inc;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_aw_hs     = r_awvalid & M_AXI.awready;
  assign w_w_hs      = r_wvalid & M_AXI.wready;
  assign w_count_inc = r_count + 1'b1;
  // Address of the next word; wraps modulo 2^ADDR_W by truncation
  assign w_word_addr = C_BASE_ADDR + ADDR_W'({r_count, 2'b00});

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state   <= ST_IDLE;
      r_awaddr  <= C_BASE_ADDR;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_count   <= w_count_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // Next-state logic: fetch a word, issue AW and W independently, wait for B
  always_comb begin
    w_state_nxt   = r_state;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_count_nxt   = r_count;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_error_nxt   = r_error;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_done_nxt  = 1'b0;
          w_error_nxt = 1'b0;
          w_count_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (w_tvalid) begin
          w_wdata_nxt   = w_tdata;
          w_awaddr_nxt  = w_word_addr;
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_state_nxt = ST_RESP;
        end
      end

      ST_RESP: begin
        if (M_AXI.bvalid) begin
          if (M_AXI.bresp == AXI_RESP_OKAY) begin
            w_count_nxt = w_count_inc;
            if (w_count_inc == C_N_WEIGHTS) begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = ST_FIN;
            end else begin
              w_state_nxt = ST_FETCH;
            end
          end else begin
            // Any non-OKAY response aborts the load with the count frozen
            w_error_nxt = 1'b1;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_FIN;
          end
        end
      end

      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_tready      = (r_state == ST_FETCH);
  assign M_AXI.awaddr  = r_awaddr;
  assign M_AXI.awprot  = 3'b000;
  assign M_AXI.awvalid = r_awvalid;
  assign M_AXI.wdata   = r_wdata;
  assign M_AXI.wstrb   = 4'b1111;
  assign M_AXI.wvalid  = r_wvalid;
  assign M_AXI.bready  = (r_state == ST_RESP);
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_axil_weight_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_axil_weight_loader                                 |
// | Purpose  : Directed self-checking bench for axil_weight_loader   |
// |            with a stream source and an AXI4-Lite slave model.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_axil_weight_loader;
  import nn_axi_pkg::*;

  localparam int N    = 784;
  localparam int AW   = 12;
  localparam int BASE = 0;
  localparam int CW   = 10;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   w_tdata;
  logic          w_tvalid;
  logic          w_tready;
  logic          busy, done, error;
  logic [CW-1:0] count;

  axil_weight_loader_if #(.ADDR_W(AW)) axi ();

  always #5 clk = ~clk;

  axil_weight_loader #(
    .N_WEIGHTS(N), .ADDR_W(AW), .BASE_ADDR(BASE), .CNT_W(CW)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn), .start(start),
    .w_tdata(w_tdata), .w_tvalid(w_tvalid), .w_tready(w_tready),
    .M_AXI(axi), .busy(busy), .done(done), .error(error), .count(count)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Shared controls driven from the main sequence
  logic        clr = 1'b0;
  logic        skew_mode = 1'b0;
  int          err_idx = -1;
  int          src_gap = 0;
  logic [31:0] src_seed = 32'h0;

  // Stream source state
  int src_idx, gap_cnt;

  // Slave model state
  int               aw_wait, w_wait, cur_aw_dly, cur_w_dly;
  logic             aw_have, w_have;
  logic [AW-1:0]    aw_addr_q;
  logic [31:0]      w_data_q;
  int               pair_cnt, aw_hs_cnt, w_hs_cnt, dup_err, stab_err, fetch_valid_err;
  logic [AW-1:0]    wr_addr [0:N+7];
  logic [31:0]      wr_data [0:N+7];
  logic             prev_aw_stall, prev_w_stall;
  logic [AW-1:0]    prev_awaddr;
  logic [31:0]      prev_wdata;
  logic             s_aw_hs, s_w_hs;

  function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
    return seed ^ (32'(i) * 32'h9E3779B1);
  endfunction

  assign w_tvalid = (gap_cnt == 0);
  assign w_tdata  = pat(src_seed, src_idx);

  // Stream source: one word per accept, then src_gap idle cycles
  always @(posedge clk) begin
    if (clr) begin
      src_idx <= 0;
      gap_cnt <= 0;
    end else if (w_tvalid && w_tready) begin
      src_idx <= src_idx + 1;
      gap_cnt <= src_gap;
    end else if (gap_cnt > 0) begin
      gap_cnt <= gap_cnt - 1;
    end
  end

  // Ready generation: in skew mode word%3==0 delays AW, ==1 delays W, ==2 neither
  always_comb begin
    cur_aw_dly  = (skew_mode && (pair_cnt % 3 == 0)) ? 3 : 0;
    cur_w_dly   = (skew_mode && (pair_cnt % 3 == 1)) ? 3 : 0;
    axi.awready = (aw_wait >= cur_aw_dly);
    axi.wready  = (w_wait >= cur_w_dly);
  end

  assign s_aw_hs = axi.awvalid & axi.awready;
  assign s_w_hs  = axi.wvalid & axi.wready;

  // Slave model: collect AW/W, respond one cycle later, log writes and protocol errors
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axi.bvalid    <= 1'b0;
      axi.bresp     <= 2'b00;
      aw_have       <= 1'b0;
      w_have        <= 1'b0;
      aw_wait       <= 0;
      w_wait        <= 0;
      prev_aw_stall <= 1'b0;
      prev_w_stall  <= 1'b0;
    end else if (clr) begin
      pair_cnt <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0;
      dup_err <= 0; stab_err <= 0; fetch_valid_err <= 0;
    end else begin
      aw_wait <= s_aw_hs ? 0 : (axi.awvalid ? aw_wait + 1 : aw_wait);
      w_wait  <= s_w_hs ? 0 : (axi.wvalid ? w_wait + 1 : w_wait);
      if (s_aw_hs) begin
        aw_hs_cnt <= aw_hs_cnt + 1;
        if (aw_have) dup_err <= dup_err + 1;
        aw_have   <= 1'b1;
        aw_addr_q <= axi.awaddr;
      end
      if (s_w_hs) begin
        w_hs_cnt <= w_hs_cnt + 1;
        if (w_have) dup_err <= dup_err + 1;
        w_have   <= 1'b1;
        w_data_q <= axi.wdata;
      end
      if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if ((aw_have || s_aw_hs) && (w_have || s_w_hs)) begin
        if (pair_cnt < N + 8) begin
          wr_addr[pair_cnt] <= s_aw_hs ? axi.awaddr : aw_addr_q;
          wr_data[pair_cnt] <= s_w_hs ? axi.wdata : w_data_q;
        end
        axi.bresp  <= (pair_cnt == err_idx) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        axi.bvalid <= 1'b1;
        pair_cnt   <= pair_cnt + 1;
        aw_have    <= 1'b0;
        w_have     <= 1'b0;
      end
      prev_aw_stall <= axi.awvalid & ~axi.awready;
      prev_w_stall  <= axi.wvalid & ~axi.wready;
      prev_awaddr   <= axi.awaddr;
      prev_wdata    <= axi.wdata;
      if (prev_aw_stall && (!axi.awvalid || axi.awaddr != prev_awaddr)) stab_err <= stab_err + 1;
      if (prev_w_stall && (!axi.wvalid || axi.wdata != prev_wdata)) stab_err <= stab_err + 1;
      if (w_tready && (axi.awvalid || axi.wvalid)) fetch_valid_err <= fetch_valid_err + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick(1);
      cycles++;
    end
    check({tag, "_done_in_budget"}, 64'(done), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input logic [31:0] seed);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr[i] !== AW'(BASE + 4 * i) || wr_data[i] !== pat(seed, i)) bad++;
    end
    check({tag, "_bad_words"}, 64'(bad), 64'd0);
    check({tag, "_aw_count"}, 64'(aw_hs_cnt), 64'(n));
    check({tag, "_w_count"}, 64'(w_hs_cnt), 64'(n));
    check({tag, "_dup"}, 64'(dup_err), 64'd0);
    check({tag, "_stable"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    int cyc;
    int ready_seen;
    // Reset state
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_tready", 64'(w_tready), 64'd0);
    check("rst_awaddr", 64'(axi.awaddr), 64'(BASE));
    check("rst_wdata", 64'(axi.wdata), 64'd0);
    check("const_strb_prot", {57'd0, axi.wstrb, axi.awprot}, {57'd0, 4'hF, 3'b000});
    aresetn = 1'b1;
    tick(2);

    // Full load, all ready, stream always valid
    src_seed = 32'h1234_5678;
    clear_stats();
    pulse_start();
    check("full_busy", 64'(busy), 64'd1);
    wait_done("full", 3000, cyc);
    check("full_cycles_in_range", 64'(cyc >= 2350 && cyc <= 2354), 64'd1);
    check("full_error", 64'(error), 64'd0);
    check("full_count", 64'(count), 64'(N));
    check("full_busy_end", 64'(busy), 64'd0);
    check_writes("full", N, 32'h1234_5678);
    check("full_last_addr", 64'(wr_addr[N-1]), 64'h0C3C);
    tick(5);
    check("full_done_held", 64'(done), 64'd1);
    check("full_no_extra_words", 64'(src_idx), 64'(N));
    check("full_tready_low", 64'(w_tready), 64'd0);

    // Channel skew: AW late, then W late, then both together, rotating per word
    src_seed = 32'hCAFE_0001;
    skew_mode = 1'b1;
    clear_stats();
    pulse_start();
    wait_done("skew", 12000, cyc);
    check("skew_count", 64'(count), 64'(N));
    check_writes("skew", N, 32'hCAFE_0001);
    skew_mode = 1'b0;
    tick(2);

    // Stream gaps of four cycles between words
    src_seed = 32'h0BAD_F00D;
    src_gap = 4;
    clear_stats();
    pulse_start();
    wait_done("gap", 8000, cyc);
    check("gap_count", 64'(count), 64'(N));
    check("gap_no_valid_in_fetch", 64'(fetch_valid_err), 64'd0);
    check_writes("gap", N, 32'h0BAD_F00D);
    src_gap = 0;
    tick(2);

    // Slave error on word 5
    src_seed = 32'h5A5A_0000;
    err_idx = 5;
    clear_stats();
    pulse_start();
    wait_done("err", 200, cyc);
    check("err_error", 64'(error), 64'd1);
    check("err_count", 64'(count), 64'd5);
    ready_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (w_tready) ready_seen++;
    end
    check("err_tready_stays_low", 64'(ready_seen), 64'd0);
    check("err_aw_total", 64'(aw_hs_cnt), 64'd6);
    check("err_words_taken", 64'(src_idx), 64'd6);
    check("err_done_held", {62'd0, done, error}, 64'd3);
    err_idx = -1;

    // Restart after error clears status; a start pulse during busy is ignored
    src_seed = 32'h7777_1111;
    clear_stats();
    pulse_start();
    check("restart_status", {60'd0, busy, done, error, 1'b0}, {60'd0, 4'b1000});
    check("restart_count", 64'(count), 64'd0);
    tick(100);
    pulse_start();
    wait_done("restart", 3000, cyc);
    check("restart_error", 64'(error), 64'd0);
    check("restart_count_end", 64'(count), 64'(N));
    check_writes("restart", N, 32'h7777_1111);
    tick(3);

    // Asynchronous reset while AW is pending, then a clean full load
    src_seed = 32'h0F0F_3C3C;
    skew_mode = 1'b1;
    clear_stats();
    pulse_start();
    cyc = 0;
    while (!(axi.awvalid && !axi.awready && count >= 3) && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("arst_reached_issue", 64'(axi.awvalid), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_valids", {62'd0, axi.awvalid, axi.wvalid}, 64'd0);
    check("arst_status", {60'd0, busy, done, error, axi.bready}, 64'd0);
    check("arst_tready", 64'(w_tready), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_regs", {axi.awaddr, axi.wdata}, {AW'(BASE), 32'd0});
    skew_mode = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(1);
    src_seed = 32'hDEAD_BEEF;
    clear_stats();
    pulse_start();
    wait_done("post_rst", 3000, cyc);
    check("post_rst_count", 64'(count), 64'(N));
    check("post_rst_error", 64'(error), 64'd0);
    check_writes("post_rst", N, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
